// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage.
//   stageState_t    : stage occupancy state (EMPTY / ONE / TWO)
//   CTRL_*          : bit positions inside the default control bus
//   CTRL_MASK_DFLT  : side-effecting control bits (RegWrite, MemWrite)
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stageState_t;

    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMWRITE  = 1;
    localparam int CTRL_RESSRC_LO = 2;

    localparam logic [3:0] CTRL_MASK_DFLT =
        4'((1 << CTRL_REGWRITE) | (1 << CTRL_MEMWRITE));

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle around one elastic stage.
//   in_valid/in_ready/in_ctrl/in_data     : upstream side of the stage
//   out_valid/out_ready/out_ctrl/out_data : downstream side of the stage
// Modports:
//   master : the surrounding pipeline (drives upstream entries, out_ready)
//   slave  : the stage itself
interface pipe_stage_elastic_if #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 133
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_entry.sv
// One stage entry: a register with load enable and synchronous clear.
//   clk  : clock
//   clr  : synchronous active-high clear (wins over load)
//   load : capture d on the rising edge
//   d    : next value
//   q    : held value
module pipe_entry #(
    parameter int W = 137
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // NOTE: the data register is cleared on reset on purpose: the stage must
    // present out_ctrl=0 and out_data=0 straight out of reset.
    always_ff @(posedge clk) begin
        if (clr)       q <= '0;
        else if (load) q <= d;
    end
endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with a 2-entry skid buffer.
//   clk       : clock, all state on the rising edge
//   rst       : synchronous active-high reset (overrides everything)
//   flush     : synchronous flush, drops held entries and same-cycle input
//   bus       : upstream/downstream valid-ready handshake (slave modport)
//   occupancy : number of entries held (0..2)
//   stall_cnt : saturating count of cycles with out_valid & !out_ready
// in_ready is decoded from the state register only, so back-pressure never
// forms a combinational path from out_ready to in_ready.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                CTRL_W    = 4,
    parameter int                DATA_W    = 133,
    parameter logic [CTRL_W-1:0] CTRL_MASK = CTRL_W'(CTRL_MASK_DFLT),
    parameter int                CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_stage_elastic_if.slave  bus,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);
    localparam int ENTRY_W = CTRL_W + DATA_W;

    stageState_t        stateQ;
    stageState_t        stateNext;
    logic               mainLoad;
    logic               skidLoad;
    logic               mainFromSkid;
    logic               outValid;
    logic [ENTRY_W-1:0] mainD;
    logic [ENTRY_W-1:0] mainQ;
    logic [ENTRY_W-1:0] skidQ;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) stateQ <= EMPTY;
        else     stateQ <= stateNext;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        stateNext    = stateQ;
        mainLoad     = 1'b0;
        skidLoad     = 1'b0;
        mainFromSkid = 1'b0;
        unique case (stateQ)
            EMPTY: begin
                if (bus.in_valid) begin
                    mainLoad  = 1'b1;
                    stateNext = ONE;
                end
            end
            ONE: begin
                if (bus.out_ready && bus.in_valid) begin
                    mainLoad = 1'b1;        // pass-through at full rate
                end else if (bus.out_ready) begin
                    stateNext = EMPTY;
                end else if (bus.in_valid) begin
                    skidLoad  = 1'b1;       // spill while downstream stalls
                    stateNext = TWO;
                end
            end
            TWO: begin
                if (bus.out_ready) begin    // input ignored: in_ready is 0
                    mainLoad     = 1'b1;
                    mainFromSkid = 1'b1;
                    stateNext    = ONE;
                end
            end
            default: stateNext = EMPTY;
        endcase
        // Flush drops everything, including an input offered this cycle.
        if (flush) begin
            stateNext = EMPTY;
            mainLoad  = 1'b0;
            skidLoad  = 1'b0;
        end
    end

    assign mainD = mainFromSkid ? skidQ : {bus.in_ctrl, bus.in_data};

    pipe_entry #(.W(ENTRY_W)) mainEntry (
        .clk  (clk),
        .clr  (rst),
        .load (mainLoad),
        .d    (mainD),
        .q    (mainQ)
    );

    pipe_entry #(.W(ENTRY_W)) skidEntry (
        .clk  (clk),
        .clr  (rst),
        .load (skidLoad),
        .d    ({bus.in_ctrl, bus.in_data}),
        .q    (skidQ)
    );

    assign outValid      = (stateQ != EMPTY);
    assign bus.out_valid = outValid;
    assign bus.in_ready  = (stateQ != TWO);
    assign occupancy     = stateQ;

    // A bubble must never carry side-effecting control bits downstream.
    assign bus.out_ctrl = mainQ[ENTRY_W-1 -: CTRL_W] & ~(outValid ? '0 : CTRL_MASK);
    assign bus.out_data = mainQ[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (outValid && !bus.out_ready && !flush
                     && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic. A queue-based model of the
// stage (at most two entries, FIFO order) predicts every output; a second
// instance with a 3-bit stall counter sees the same stimulus to exercise
// counter saturation.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int CTRL_W  = 4;
    localparam int DATA_W  = 133;
    localparam int CNT_W   = 16;
    localparam int SAT_W   = 3;
    localparam int ENTRY_W = CTRL_W + DATA_W;
    localparam logic [CTRL_W-1:0] MASK = 4'b0011;
    localparam int MAIN_MAX = (1 << CNT_W) - 1;
    localparam int SAT_MAX  = (1 << SAT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [1:0]       occupancy;
    logic [1:0]       satOcc;
    logic [CNT_W-1:0] stallCnt;
    logic [SAT_W-1:0] satStall;

    always #5 clk = ~clk;

    pipe_stage_elastic_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();
    pipe_stage_elastic_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) satBus ();

    assign satBus.in_valid  = bus.in_valid;
    assign satBus.in_ctrl   = bus.in_ctrl;
    assign satBus.in_data   = bus.in_data;
    assign satBus.out_ready = bus.out_ready;

    pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_MASK(MASK), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy),
        .stall_cnt (stallCnt)
    );

    pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_MASK(MASK), .CNT_W(SAT_W)) satDut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (satBus),
        .occupancy (satOcc),
        .stall_cnt (satStall)
    );

    // Reference model state.
    logic [ENTRY_W-1:0] q[$];
    int cntMain;
    int cntSat;

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkOutputs();
        logic [ENTRY_W-1:0] head;
        check("in_ready",  bus.in_ready,  q.size() < 2);
        check("out_valid", bus.out_valid, q.size() != 0);
        check("occupancy", occupancy,     q.size());
        check("stall_cnt", stallCnt,      cntMain);
        check("sat_stall", satStall,      cntSat);
        check("sat_valid", satBus.out_valid, q.size() != 0);
        check("sat_occ",   satOcc,        q.size());
        if (q.size() != 0) begin
            head = q[0];
            check("out_ctrl", bus.out_ctrl, head[ENTRY_W-1 -: CTRL_W]);
            check("out_data", bus.out_data, head[DATA_W-1:0]);
        end else begin
            check("bubble_ctrl", bus.out_ctrl & MASK, 0);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then check after the edge.
    task automatic cycle(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic ordy, input logic fl, input logic r);
        bit wasValid;
        bit canTake;
        bus.in_valid  = v;
        bus.in_ctrl   = c;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        rst           = r;
        wasValid = (q.size() != 0);
        canTake  = (q.size() < 2);
        if (r) begin
            q.delete();
            cntMain = 0;
            cntSat  = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (wasValid && !ordy) begin
                if (cntMain < MAIN_MAX) cntMain++;
                if (cntSat  < SAT_MAX)  cntSat++;
            end
            if (wasValid && ordy) void'(q.pop_front());
            if (v && canTake) q.push_back({c, d});
        end
        @(posedge clk);
        #1;
        checkOutputs();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [159:0] wide;
        cntMain = 0;
        cntSat  = 0;

        // Reset while upstream drives a fully-set entry.
        cycle(1'b1, 4'hF, {DATA_W{1'b1}}, 1'b0, 1'b0, 1'b1);
        check("rst_out_ctrl", bus.out_ctrl, 0);
        check("rst_out_data", bus.out_data, 0);

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++)
            cycle(1'b1, 4'(i), DATA_W'(i), 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Back-pressure: A, B fill the stage, C waits upstream.
        cycle(1'b1, 4'h1, DATA_W'('h11), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, DATA_W'('h22), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h3, DATA_W'('h33), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h3, DATA_W'('h33), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h3, DATA_W'('h33), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'h3, DATA_W'('h33), 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Flush while full, with D offered in the same cycle.
        cycle(1'b1, 4'h5, DATA_W'('h55), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h6, DATA_W'('h66), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h4, DATA_W'('h44), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Bubble gating after a fully-set control word.
        cycle(1'b1, 4'hF, DATA_W'('h77), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Counter saturation on the 3-bit instance.
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'hF, DATA_W'('h88), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        check("sat_final", satStall, SAT_MAX);
        idle(1'b1);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            wide = {$urandom, $urandom, $urandom, $urandom, $urandom};
            cycle(1'($urandom_range(0, 1)), 4'($urandom), wide[DATA_W-1:0],
                  1'($urandom % 4 != 0), 1'($urandom % 20 == 0), 1'($urandom % 80 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised elastic pipeline stage register for the pipelined RISC-V core. Successor to the fixed stage registers such as EX/MEM.
- Carries a control bus and a payload bus between stages with a valid/ready handshake, a 2-entry skid buffer, flush, and bubble-safe control gating.
- Provides full throughput (1 transfer per cycle) while stall back-pressure is absorbed without a combinational ready path.
- Includes a saturating stall-cycle counter for performance debug.

Parameters:
- CTRL_W, 4: control bus width. Default bit order: [0] RegWrite, [1] MemWrite, [3:2] ResultSrc.
- DATA_W, 133: payload width. Default packs Rd[4:0], ALUResult, WriteData, ExtImm, PCPlus4.
- CTRL_MASK, 4'b0011: control bits that are side-effecting. These bits are forced to 0 whenever out_valid=0.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous flush; discards all held entries and any input accepted in the same cycle.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bus.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_ctrl/out_data hold a valid entry.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control bus, masked by CTRL_MASK when not valid.
- out_data  out  DATA_W  payload.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturates at all-ones.

Behaviour:
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Storage: main entry drives the outputs; skid entry holds the spill.
- States:
  - EMPTY: occupancy 0.
  - ONE: main full.
  - TWO: main and skid full.
- Port derivation: in_ready = (state != TWO), decoded from the state register only, with no combinational path from out_ready. out_valid = (state != EMPTY).
- Transitions (when neither rst nor flush is asserted):
  - EMPTY: in_valid -> load main, go to ONE.
  - ONE, out_ready & in_valid: load main with the input, stay in ONE.
  - ONE, out_ready & !in_valid: go to EMPTY.
  - ONE, !out_ready & in_valid: load skid, go to TWO.
  - ONE, neither: hold.
  - TWO, out_ready: main <= skid, go to ONE. Input is ignored because in_ready=0.
  - TWO, !out_ready: hold.
- Latency and ordering: 1 cycle from input transfer to out_valid. Order is strictly FIFO. No entry is duplicated or dropped except by flush or rst.
- Control gating: out_ctrl = main_ctrl & ~(CTRL_MASK when !out_valid). A bubble never asserts RegWrite or MemWrite. Unmasked bits and out_data are don't-care when invalid.
- flush:
  - Next state is EMPTY. The input in the same cycle is dropped even if in_valid=1.
  - in_ready is 1 in the following cycle.
  - Data registers need not clear.
  - stall_cnt is unaffected.
- rst:
  - Overrides flush and all other inputs.
  - Next state is EMPTY; main/skid ctrl and data are cleared to 0; stall_cnt is cleared to 0.
- Reset values: out_valid=0, in_ready=1, occupancy=0, out_ctrl=0, out_data=0, stall_cnt=0.
- stall_cnt: increments by 1 in any cycle with out_valid & !out_ready & !flush & !rst. Holds at 2^CNT_W-1 once reached.
- Simultaneous events:
  - In ONE with in_valid and out_ready both high, the stage passes through at full rate.
  - In TWO with out_ready high, the skid drains and in_ready rises next cycle.
- Parameter legality: CTRL_W>=1, DATA_W>=1, CNT_W>=1. CTRL_MASK width equals CTRL_W.

Decomposition:
- Package pipe_pkg:
  - State encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - Control bit index constants: CTRL_REGWRITE=0, CTRL_MEMWRITE=1, CTRL_RESSRC_LO=2.
  - Default CTRL_MASK.
- Sub-module pipe_entry (CTRL_W+DATA_W wide): register with load enable and synchronous clear, instantiated twice (main and skid).
- FSM, gating and counter live in the top module.

Test Plan:
- Reset with ctrl=4'hF, data=all-ones driven and in_valid=1 -> next cycle out_valid=0, in_ready=1, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
- Streaming: out_ready=1, 8 back-to-back inputs with data=1..8 -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready constantly 1.
- Back-pressure: send A=0x11, B=0x22 with out_ready=0 -> occupancy=2 and in_ready=0 on the cycle after B. C=0x33 is held at upstream. Release out_ready -> outputs A, B, C in order with no loss. stall_cnt equals the number of stalled valid cycles.
- Flush in TWO while in_valid=1 with D=0x44 -> next cycle out_valid=0, occupancy=0, in_ready=1, D never appears at the output.
- Bubble gating: upstream sends ctrl=4'b1111 then idles -> while out_valid=0, out_ctrl[1:0]=2'b00 on every cycle.
- Counter saturation: CNT_W=3, hold out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt reaches 7 and stays there.
